// File: rtl/lab1_truth_table_sweeper_if.sv
// Handshake/bus bundle between the truth-table sweeper and its surroundings:
// the start request and sweep status, plus the drive lines into the gate unit
// and the gate unit's three outputs coming back.
//   slave  : the sweeper's view (consumes start and gate outputs, drives the rest)
//   master : the controller / gate-unit side view
interface lab1_truth_table_sweeper_if;
    logic       start;
    logic       dutAND;
    logic       dutOR;
    logic       dutNOT;
    logic       driveA;
    logic       driveB;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] errCount;
    logic [3:0] failVec;

    modport slave (
        input  start, dutAND, dutOR, dutNOT,
        output driveA, driveB, busy, done, pass, errCount, failVec
    );

    modport master (
        output start, dutAND, dutOR, dutNOT,
        input  driveA, driveB, busy, done, pass, errCount, failVec
    );
endinterface

// File: rtl/lab1_truth_table_sweeper.sv
// Truth-table sweeper for the NOR-built AND/OR/NOT gate unit.
// Walks {A,B} through 00,01,10,11, holds each for SETTLE_CYCLES cycles, then
// samples the unit's outputs for one cycle and compares against golden values.
// Per-combo failures accumulate in failVec/errCount; pass is valid alongside
// the one-cycle done pulse and held until the next start.
// Build option: define LAB1_SWEEP_STOP_ON_FAIL_EN to end the sweep at the
// first mismatching combo and leave the drive lines parked on that combo.
module lab1_truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    lab1_truth_table_sweeper_if.slave   bus
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("lab1_truth_table_sweeper: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t     state_q, state_d;
    logic [1:0] combo_q, combo_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [2:0] err_q,   err_d;
    logic [3:0] fail_q,  fail_d;
    logic       pass_q,  pass_d;

    logic       exp_and, exp_or, exp_not;
    logic       mismatch;

    // Golden response for the combo currently on the drive lines. The compare
    // uses case equality so an X/Z coming back from the unit is a mismatch.
    always_comb begin
        exp_and  = combo_q[1] & combo_q[0];
        exp_or   = combo_q[1] | combo_q[0];
        exp_not  = ~combo_q[1];
        mismatch = !((bus.dutAND === exp_and) &&
                     (bus.dutOR  === exp_or)  &&
                     (bus.dutNOT === exp_not));
    end

    // State, combo, settle counter and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            combo_q <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            combo_q <= combo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state and result update; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        combo_d = combo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                    combo_d = 2'd0;
                    cnt_d   = SETTLE_LD;
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                // Counter was loaded with SETTLE_CYCLES; leaving at 1 gives
                // exactly SETTLE_CYCLES cycles of drive before the sample.
                if (cnt_q <= 4'd1) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    fail_d[combo_q] = 1'b1;
                    err_d           = err_q + 3'd1;
                end
`ifdef LAB1_SWEEP_STOP_ON_FAIL_EN
                if (mismatch || combo_q == 2'd3) begin
                    // pass is settled here so it is valid during the done pulse
                    pass_d  = (err_d == 3'd0);
                    state_d = DONE;
                end else begin
                    combo_d = combo_q + 2'd1;
                    cnt_d   = SETTLE_LD;
                    state_d = DRIVE;
                end
`else
                if (combo_q == 2'd3) begin
                    // pass is settled here so it is valid during the done pulse
                    pass_d  = (err_d == 3'd0);
                    state_d = DONE;
                end else begin
                    combo_d = combo_q + 2'd1;
                    cnt_d   = SETTLE_LD;
                    state_d = DRIVE;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
`ifdef LAB1_SWEEP_STOP_ON_FAIL_EN
                // Park on the failing combo for probing; a clean sweep
                // still returns the lines to 0.
                if (pass_q) begin
                    combo_d = 2'd0;
                end
`else
                combo_d = 2'd0;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs straight from registers.
    always_comb begin
        bus.driveA   = combo_q[1];
        bus.driveB   = combo_q[0];
        bus.busy     = (state_q == DRIVE) || (state_q == SAMPLE);
        bus.done     = (state_q == DONE);
        bus.pass     = pass_q;
        bus.errCount = err_q;
        bus.failVec  = fail_q;
    end

endmodule

// File: tb/tb_lab1_truth_table_sweeper.sv
// Directed bench for lab1_truth_table_sweeper: a SETTLE=2 instance and a
// SETTLE=1 instance share start/reset, each fed by a NOR-built gate model
// with a selectable fault.
module tb_lab1_truth_table_sweeper;

    logic clk;
    logic reset;
    logic start;
    int   fault;   // 0 good, 1 AND stuck 0, 2 NOT stuck 1, 3 all outputs inverted
    int   total;
    int   bad;

    lab1_truth_table_sweeper_if ifa ();
    lab1_truth_table_sweeper_if ifb ();

    lab1_truth_table_sweeper #(.SETTLE_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    lab1_truth_table_sweeper #(.SETTLE_CYCLES(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    assign ifa.start  = start;
    assign ifb.start  = start;
    assign ifa.dutAND = (fault == 1) ? 1'b0 : (fault == 3) ? (~ifa.driveA | ~ifa.driveB) : ~(~ifa.driveA | ~ifa.driveB);
    assign ifa.dutOR  = (fault == 3) ? ~(ifa.driveA | ifa.driveB) : ~(~(ifa.driveA | ifa.driveB));
    assign ifa.dutNOT = (fault == 2) ? 1'b1 : (fault == 3) ? ifa.driveA : ~(ifa.driveA | ifa.driveA);
    assign ifb.dutAND = (fault == 1) ? 1'b0 : (fault == 3) ? (~ifb.driveA | ~ifb.driveB) : ~(~ifb.driveA | ~ifb.driveB);
    assign ifb.dutOR  = (fault == 3) ? ~(ifb.driveA | ifb.driveB) : ~(~(ifb.driveA | ifb.driveB));
    assign ifb.dutNOT = (fault == 2) ? 1'b1 : (fault == 3) ? ifb.driveA : ~(ifb.driveA | ifb.driveA);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         dcyc_a, dcyc_b, npulse_a;
    logic       pass_a, pass_b, pass_mid, busy_c1;
    logic [2:0] err_a;
    logic [3:0] fv_a;
    logic [1:0] tr_a [1:20];
    logic [1:0] tr_b [1:20];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start pulse on a clock edge, then 20 cycles observed at #1 after each
    // edge; cycle 1 is the cycle right after the start edge.
    task automatic sweep(input bit inj);
        dcyc_a = 0; dcyc_b = 0; npulse_a = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            start = inj && (c == 3 || c == 7);
            tr_a[c] = {ifa.driveA, ifa.driveB};
            tr_b[c] = {ifb.driveA, ifb.driveB};
            if (c == 1) busy_c1 = ifa.busy;
            if (c == 2) pass_mid = ifa.pass;
            if (ifa.done) begin
                npulse_a++;
                if (dcyc_a == 0) begin
                    dcyc_a = c; pass_a = ifa.pass; err_a = ifa.errCount; fv_a = ifa.failVec;
                end
            end
            if (ifb.done && dcyc_b == 0) begin
                dcyc_b = c; pass_b = ifb.pass;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int seen_done;
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; fault = 0;
        #3;
        chk("reset_ctl",  {3'b0, ifa.busy, ifa.done, ifa.pass, ifa.driveA, ifa.driveB}, 8'h00);
        chk("reset_err",  {5'b0, ifa.errCount}, 8'h00);
        chk("reset_fail", {4'b0, ifa.failVec},  8'h00);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // Good unit: both instances
        sweep(1'b0);
        chk("good_done_cyc",  8'(dcyc_a), 8'd13);
        chk("good_pulses",    8'(npulse_a), 8'd1);
        chk("good_busy",      {7'b0, busy_c1}, 8'd1);
        chk("good_pass",      {7'b0, pass_a}, 8'd1);
        chk("good_err",       {5'b0, err_a}, 8'd0);
        chk("good_fail",      {4'b0, fv_a}, 8'h0);
        chk("good_drv_c1",    {6'b0, tr_a[1]},  8'd0);
        chk("good_drv_c4",    {6'b0, tr_a[4]},  8'd1);
        chk("good_drv_c7",    {6'b0, tr_a[7]},  8'd2);
        chk("good_drv_c10",   {6'b0, tr_a[10]}, 8'd3);
        chk("good_drv_end",   {6'b0, tr_a[20]}, 8'd0);
        chk("good_pass_held", {7'b0, ifa.pass}, 8'd1);
        chk("s1_done_cyc",    8'(dcyc_b), 8'd9);
        chk("s1_pass",        {7'b0, pass_b}, 8'd1);
        chk("s1_drv_c1",      {6'b0, tr_b[1]}, 8'd0);
        chk("s1_drv_c3",      {6'b0, tr_b[3]}, 8'd1);
        chk("s1_drv_c5",      {6'b0, tr_b[5]}, 8'd2);
        chk("s1_drv_c7",      {6'b0, tr_b[7]}, 8'd3);
        chk("s1_drv_c10",     {6'b0, tr_b[10]}, 8'd0);

        // Extra start pulses at cycles 3 and 7 are ignored
        sweep(1'b1);
        chk("inj_pass_clr",  {7'b0, pass_mid}, 8'd0);
        chk("inj_done_cyc",  8'(dcyc_a), 8'd13);
        chk("inj_pulses",    8'(npulse_a), 8'd1);
        chk("inj_pass",      {7'b0, pass_a}, 8'd1);

        // AND stuck at 0: only combo 3 fails
        fault = 1;
        sweep(1'b0);
        chk("and0_done_cyc", 8'(dcyc_a), 8'd13);
        chk("and0_fail",     {4'b0, fv_a}, 8'b1000);
        chk("and0_err",      {5'b0, err_a}, 8'd1);
        chk("and0_pass",     {7'b0, pass_a}, 8'd0);
`ifdef LAB1_SWEEP_STOP_ON_FAIL_EN
        chk("and0_drv_end",  {6'b0, tr_a[20]}, 8'd3);
`else
        chk("and0_drv_end",  {6'b0, tr_a[20]}, 8'd0);
`endif

        // NOT stuck at 1: combos 2 and 3 fail
        fault = 2;
        sweep(1'b0);
`ifdef LAB1_SWEEP_STOP_ON_FAIL_EN
        chk("not1_done_cyc", 8'(dcyc_a), 8'd10);
        chk("not1_fail",     {4'b0, fv_a}, 8'b0100);
        chk("not1_err",      {5'b0, err_a}, 8'd1);
        chk("not1_drv_end",  {6'b0, tr_a[20]}, 8'b10);
`else
        chk("not1_done_cyc", 8'(dcyc_a), 8'd13);
        chk("not1_fail",     {4'b0, fv_a}, 8'b1100);
        chk("not1_err",      {5'b0, err_a}, 8'd2);
        chk("not1_drv_end",  {6'b0, tr_a[20]}, 8'd0);
`endif
        chk("not1_pass",     {7'b0, pass_a}, 8'd0);

        // Every output inverted: every combo fails, errCount at its maximum
        fault = 3;
        sweep(1'b0);
`ifdef LAB1_SWEEP_STOP_ON_FAIL_EN
        chk("inv_done_cyc", 8'(dcyc_a), 8'd4);
        chk("inv_fail",     {4'b0, fv_a}, 8'b0001);
        chk("inv_err",      {5'b0, err_a}, 8'd1);
`else
        chk("inv_done_cyc", 8'(dcyc_a), 8'd13);
        chk("inv_fail",     {4'b0, fv_a}, 8'b1111);
        chk("inv_err",      {5'b0, err_a}, 8'd4);
`endif

        // Reset at cycle 6 of a good sweep
        fault = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_busy", {7'b0, ifa.busy}, 8'd1);
        chk("rst_pre_drv",  {6'b0, ifa.driveA, ifa.driveB}, 8'd1);
        reset = 1'b1;
        #1;
        chk("rst_ctl",  {3'b0, ifa.busy, ifa.done, ifa.pass, ifa.driveA, ifa.driveB}, 8'h00);
        chk("rst_err",  {5'b0, ifa.errCount}, 8'h00);
        chk("rst_fail", {4'b0, ifa.failVec},  8'h00);
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ifa.done) seen_done++;
        end
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ifa.done) seen_done++;
        end
        chk("rst_no_done", 8'(seen_done), 8'd0);
        sweep(1'b0);
        chk("rst_after_done_cyc", 8'(dcyc_a), 8'd13);
        chk("rst_after_pass",     {7'b0, pass_a}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
